id_ex_stage: RTL and testbench

- Pipeline register between instruction decode and the EX stage; registers decoded operands and control, then drives the 32-bit ALU (a, b, 4-bit ula_control).
- Applies EX/MEM and MEM/WB forwarding to the registered operands.
- Decodes alu_op/funct into ula_control.
- Flags load-use hazards back to decode; supports stall (hold) and flush (bubble).

---
 rtl/id_ex_stage.sv | 187 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands and control, decodes the
// ALU operation, applies EX/MEM and MEM/WB forwarding to the registered source
// operands, and raises a combinational load-use hazard request to decode.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    input  logic [DW-1:0] imm,
    input  logic [RW-1:0] rs_addr,
    input  logic [RW-1:0] rt_addr,
    input  logic [RW-1:0] rd_addr,
    input  logic          alu_src,
    input  logic          reg_dst,
    input  logic          reg_write,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic          mem_to_reg,
    input  logic [1:0]    alu_op,
    input  logic [5:0]    funct,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] a,
    output logic [DW-1:0] b,
    output logic [3:0]    ula_control,
    output logic [DW-1:0] store_data,
    output logic [RW-1:0] wr_addr,
    output logic          reg_write_o,
    output logic          mem_read_o,
    output logic          mem_write_o,
    output logic          mem_to_reg_o,
    output logic          valid_o,
    output logic          load_use_hazard
);

    // Pipeline registers
    logic          valid_r;
    logic          reg_write_r;
    logic          mem_read_r;
    logic          mem_write_r;
    logic          mem_to_reg_r;
    logic          alu_src_r;
    logic [3:0]    ula_control_r;
    logic [RW-1:0] wr_addr_r;
    logic [RW-1:0] rs_addr_r;
    logic [RW-1:0] rt_addr_r;
    logic [DW-1:0] rs_data_r;
    logic [DW-1:0] rt_data_r;
    logic [DW-1:0] imm_r;

    // Forwarded operands
    logic [DW-1:0] fwd_rs_s;
    logic [DW-1:0] fwd_rt_s;
    logic [DW-1:0] b_s;

    // ALU operation decode; anything unrecognised falls back to add.
    function automatic logic [3:0] ula_decode(input logic [1:0] op, input logic [5:0] fn);
        logic [3:0] res;
        case (op)
            2'b00:   res = 4'b0000;
            2'b01:   res = 4'b0001;
            2'b10: begin
                case (fn)
                    6'b100000: res = 4'b0000;
                    6'b100010: res = 4'b0001;
                    6'b100100: res = 4'b0010;
                    6'b100101: res = 4'b0011;
                    6'b101010: res = 4'b0100;
                    default:   res = 4'b0000;
                endcase
            end
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    // Forwarding mux: the younger EX/MEM result wins; register 0 is never forwarded.
    function automatic logic [DW-1:0] fwd_sel(
        input logic [RW-1:0] src,
        input logic [DW-1:0] reg_val,
        input logic          em_we,
        input logic [RW-1:0] em_rd,
        input logic [DW-1:0] em_val,
        input logic          mw_we,
        input logic [RW-1:0] mw_rd,
        input logic [DW-1:0] mw_val
    );
        logic [DW-1:0] res;
        if (src == {RW{1'b0}}) begin
            res = reg_val;
        end else if (em_we && (em_rd == src)) begin
            res = em_val;
        end else if (mw_we && (mw_rd == src)) begin
            res = mw_val;
        end else begin
            res = reg_val;
        end
        return res;
    endfunction

    // Stage register: reset clears, flush inserts a bubble, stall holds, else capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r       <= 1'b0;
            reg_write_r   <= 1'b0;
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
            mem_to_reg_r  <= 1'b0;
            alu_src_r     <= 1'b0;
            ula_control_r <= 4'b0000;
            wr_addr_r     <= {RW{1'b0}};
            rs_addr_r     <= {RW{1'b0}};
            rt_addr_r     <= {RW{1'b0}};
            rs_data_r     <= {DW{1'b0}};
            rt_data_r     <= {DW{1'b0}};
            imm_r         <= {DW{1'b0}};
        end else if (flush) begin
            valid_r       <= 1'b0;
            reg_write_r   <= 1'b0;
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
            mem_to_reg_r  <= 1'b0;
            alu_src_r     <= 1'b0;
            ula_control_r <= 4'b0000;
            wr_addr_r     <= {RW{1'b0}};
            rs_addr_r     <= {RW{1'b0}};
            rt_addr_r     <= {RW{1'b0}};
            rs_data_r     <= {DW{1'b0}};
            rt_data_r     <= {DW{1'b0}};
            imm_r         <= {DW{1'b0}};
        end else if (!stall) begin
            // Control is qualified by in_valid so an empty slot cannot write state.
            valid_r       <= in_valid;
            reg_write_r   <= in_valid & reg_write;
            mem_read_r    <= in_valid & mem_read;
            mem_write_r   <= in_valid & mem_write;
            mem_to_reg_r  <= in_valid & mem_to_reg;
            alu_src_r     <= in_valid & alu_src;
            ula_control_r <= in_valid ? ula_decode(alu_op, funct) : 4'b0000;
            wr_addr_r     <= reg_dst ? rd_addr : rt_addr;
            rs_addr_r     <= rs_addr;
            rt_addr_r     <= rt_addr;
            rs_data_r     <= rs_data;
            rt_data_r     <= rt_data;
            imm_r         <= imm;
        end
    end

    // Operand forwarding and B-operand select on the registered source numbers.
    always_comb begin
        fwd_rs_s = fwd_sel(rs_addr_r, rs_data_r, exmem_reg_write, exmem_rd, exmem_result,
                           memwb_reg_write, memwb_rd, memwb_result);
        fwd_rt_s = fwd_sel(rt_addr_r, rt_data_r, exmem_reg_write, exmem_rd, exmem_result,
                           memwb_reg_write, memwb_rd, memwb_result);
        if (alu_src_r) begin
            b_s = imm_r;
        end else begin
            b_s = fwd_rt_s;
        end
    end

    assign a            = fwd_rs_s;
    assign b            = b_s;
    assign store_data   = fwd_rt_s;
    assign ula_control  = ula_control_r;
    assign wr_addr      = wr_addr_r;
    assign reg_write_o  = reg_write_r;
    assign mem_read_o   = mem_read_r;
    assign mem_write_o  = mem_write_r;
    assign mem_to_reg_o = mem_to_reg_r;
    assign valid_o      = valid_r;

    // A load in this stage whose destination feeds the instruction now in decode.
    assign load_use_hazard = valid_r & mem_read_r & in_valid & (wr_addr_r != {RW{1'b0}}) &
                             ((wr_addr_r == rs_addr) | (wr_addr_r == rt_addr));

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the stage outputs.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, in_valid;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] a, b, store_data;
    logic [3:0]  ula_control;
    logic [4:0]  wr_addr;
    logic        reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o, load_use_hazard;

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] store;
        logic [3:0]  ula;
        logic [4:0]  wr;
        logic        rw, mr, mw, mtr, valid, haz;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .alu_src(alu_src), .reg_dst(reg_dst), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_op(alu_op), .funct(funct),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .a(a), .b(b), .ula_control(ula_control), .store_data(store_data), .wr_addr(wr_addr),
        .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_to_reg_o(mem_to_reg_o), .valid_o(valid_o), .load_use_hazard(load_use_hazard)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%h expected=%h", tag, fld, act, exp);
        end
    endtask

    // Monitor: compare every pending expectation against the outputs at the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.tag, "a",           a,                        e.a);
            chk(e.tag, "b",           b,                        e.b);
            chk(e.tag, "store_data",  store_data,               e.store);
            chk(e.tag, "ula_control", {28'd0, ula_control},     {28'd0, e.ula});
            chk(e.tag, "wr_addr",     {27'd0, wr_addr},         {27'd0, e.wr});
            chk(e.tag, "reg_write_o", {31'd0, reg_write_o},     {31'd0, e.rw});
            chk(e.tag, "mem_read_o",  {31'd0, mem_read_o},      {31'd0, e.mr});
            chk(e.tag, "mem_write_o", {31'd0, mem_write_o},     {31'd0, e.mw});
            chk(e.tag, "mem_to_reg_o",{31'd0, mem_to_reg_o},    {31'd0, e.mtr});
            chk(e.tag, "valid_o",     {31'd0, valid_o},         {31'd0, e.valid});
            chk(e.tag, "hazard",      {31'd0, load_use_hazard}, {31'd0, e.haz});
        end
    end

    task automatic expect_out(input string tag, input logic [31:0] ea, eb, es,
                              input logic [3:0] eu, input logic [4:0] ew,
                              input logic erw, emr, emw, emtr, evalid, ehaz);
        exp_t e;
        e.tag = tag; e.a = ea; e.b = eb; e.store = es; e.ula = eu; e.wr = ew;
        e.rw = erw; e.mr = emr; e.mw = emw; e.mtr = emtr; e.valid = evalid; e.haz = ehaz;
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        rs_data = 32'd0; rt_data = 32'd0; imm = 32'd0;
        rs_addr = 5'd0; rt_addr = 5'd0; rd_addr = 5'd0;
        alu_src = 1'b0; reg_dst = 1'b0; reg_write = 1'b0; mem_read = 1'b0;
        mem_write = 1'b0; mem_to_reg = 1'b0; alu_op = 2'b00; funct = 6'd0;
        exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
        memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        #1;
        expect_out("reset", 32'd0, 32'd0, 32'd0, 4'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Valid add, then reset mid-cycle must clear outputs before the next edge
        in_valid = 1'b1; alu_op = 2'b00; rs_data = 32'd3; rt_data = 32'd4;
        rs_addr = 5'd1; rt_addr = 5'd2; rd_addr = 5'd3; reg_dst = 1'b1; reg_write = 1'b1;
        tick();
        expect_out("add", 32'd3, 32'd4, 32'd4, 4'd0, 5'd3, 1, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        expect_out("async_reset", 32'd0, 32'd0, 32'd0, 4'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        clear_inputs();

        // R-type slt, no forwarding
        in_valid = 1'b1; alu_op = 2'b10; funct = 6'b101010; rs_data = 32'd5; rt_data = 32'd9;
        rs_addr = 5'd4; rt_addr = 5'd6; rd_addr = 5'd7; reg_dst = 1'b1; reg_write = 1'b1;
        tick();
        expect_out("slt", 32'd5, 32'd9, 32'd9, 4'd4, 5'd7, 1, 0, 0, 0, 1, 0);

        // Both stages match r8: EX/MEM wins
        funct = 6'b100010; rs_addr = 5'd8; rt_addr = 5'd8; rd_addr = 5'd9;
        rs_data = 32'h100; rt_data = 32'h200;
        exmem_reg_write = 1'b1; exmem_rd = 5'd8; exmem_result = 32'h11;
        memwb_reg_write = 1'b1; memwb_rd = 5'd8; memwb_result = 32'h22;
        tick();
        expect_out("fwd_both", 32'h11, 32'h11, 32'h11, 4'd1, 5'd9, 1, 0, 0, 0, 1, 0);

        // Register 0 is never forwarded
        funct = 6'b100100; rs_addr = 5'd0; rt_addr = 5'd0; rd_addr = 5'd10;
        exmem_rd = 5'd0; memwb_rd = 5'd0;
        tick();
        expect_out("fwd_r0", 32'h100, 32'h200, 32'h200, 4'd2, 5'd10, 1, 0, 0, 0, 1, 0);

        // rs from EX/MEM, rt from MEM/WB
        funct = 6'b100101; rs_addr = 5'd1; rt_addr = 5'd2; rd_addr = 5'd11;
        exmem_rd = 5'd1; memwb_rd = 5'd2;
        tick();
        expect_out("fwd_split", 32'h11, 32'h22, 32'h22, 4'd3, 5'd11, 1, 0, 0, 0, 1, 0);
        clear_inputs();

        // lw r3, then dependent instruction in decode while stalled -> hazard
        in_valid = 1'b1; alu_op = 2'b00; alu_src = 1'b1; imm = 32'h10;
        rs_addr = 5'd5; rs_data = 32'h1000; rt_addr = 5'd3; rt_data = 32'h77; rd_addr = 5'd0;
        reg_dst = 1'b0; mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1;
        tick();
        stall = 1'b1; rs_addr = 5'd7; rt_addr = 5'd3; rs_data = 32'h55; alu_op = 2'b01;
        alu_src = 1'b0; mem_read = 1'b0; mem_to_reg = 1'b0; mem_write = 1'b1;
        #1;
        expect_out("load_use", 32'h1000, 32'h10, 32'h77, 4'd0, 5'd3, 1, 1, 0, 1, 1, 1);
        flush = 1'b1;
        tick();
        expect_out("flush_bubble", 32'd0, 32'd0, 32'd0, 4'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        clear_inputs();

        // Stall for three cycles while decode inputs change
        in_valid = 1'b1; alu_op = 2'b01; rs_data = 32'd20; rt_data = 32'd8;
        rs_addr = 5'd11; rt_addr = 5'd12; rd_addr = 5'd13; reg_dst = 1'b1; reg_write = 1'b1;
        tick();
        expect_out("pre_stall", 32'd20, 32'd8, 32'd8, 4'd1, 5'd13, 1, 0, 0, 0, 1, 0);
        stall = 1'b1; alu_op = 2'b10; funct = 6'b100100; rt_data = 32'hBB; rd_addr = 5'd14;
        mem_write = 1'b1; reg_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rs_data = 32'hA0 + i;
            tick();
            expect_out("stall_hold", 32'd20, 32'd8, 32'd8, 4'd1, 5'd13, 1, 0, 0, 0, 1, 0);
        end
        rs_data = 32'hAA;
        stall = 1'b0;
        tick();
        expect_out("stall_release", 32'hAA, 32'hBB, 32'hBB, 4'd2, 5'd14, 0, 0, 1, 0, 1, 0);
        clear_inputs();

        // sw with immediate offset and store data forwarded from MEM/WB
        in_valid = 1'b1; alu_op = 2'b00; alu_src = 1'b1; imm = 32'hFFFFFFFC;
        rs_addr = 5'd29; rs_data = 32'h2000; rt_addr = 5'd6; rt_data = 32'h99; mem_write = 1'b1;
        memwb_reg_write = 1'b1; memwb_rd = 5'd6; memwb_result = 32'hAB;
        tick();
        expect_out("sw_fwd", 32'h2000, 32'hFFFFFFFC, 32'hAB, 4'd0, 5'd6, 0, 0, 1, 0, 1, 0);
        clear_inputs();

        // Empty slot: control captured as 0
        in_valid = 1'b0; reg_write = 1'b1; mem_read = 1'b1; mem_write = 1'b1; mem_to_reg = 1'b1;
        rs_data = 32'd1; rt_data = 32'd2; rs_addr = 5'd1; rt_addr = 5'd2; rd_addr = 5'd2;
        reg_dst = 1'b1;
        tick();
        expect_out("invalid_slot", 32'd1, 32'd2, 32'd2, 4'd0, 5'd2, 0, 0, 0, 0, 0, 0);
        clear_inputs();

        // Reserved alu_op and unknown funct decode to add
        in_valid = 1'b1; alu_op = 2'b11; funct = 6'b100010; rs_data = 32'd6; rt_data = 32'd7;
        rs_addr = 5'd1; rt_addr = 5'd2;
        tick();
        expect_out("op_reserved", 32'd6, 32'd7, 32'd7, 4'd0, 5'd2, 0, 0, 0, 0, 1, 0);
        alu_op = 2'b10; funct = 6'b000000;
        tick();
        expect_out("funct_unknown", 32'd6, 32'd7, 32'd7, 4'd0, 5'd2, 0, 0, 0, 0, 1, 0);

        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
